// File: rtl/bp_pkg.sv
// ============================================================================
//  Module   : bp_pkg
//  Purpose  : Shared encodings for the gshare branch predictor: 2-bit
//             counter states, the default sweep value, FSM states and a
//             table-sizing helper.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bp_pkg;

    // Two-bit saturating counter encodings; the prediction is bit 1.
    localparam logic [1:0] SNT = 2'b00;  // strong not-taken
    localparam logic [1:0] WNT = 2'b01;  // weak not-taken
    localparam logic [1:0] WT  = 2'b10;  // weak taken
    localparam logic [1:0] ST  = 2'b11;  // strong taken

    // Value written to every entry by the post-reset sweep.
    localparam logic [1:0] CNT_INIT_DEFAULT = WNT;

    // INIT sweeps the table after reset; RUN predicts and trains.
    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_t;

    // Number of index bits needed to address a table of the given depth.
    function automatic int unsigned idx_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Saturating step of a counter towards the resolved outcome.
    function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == ST)  ? ST  : cnt + 2'd1;
        end
        return (cnt == SNT) ? SNT : cnt - 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pht_ram.sv
// ============================================================================
//  Module   : pht_ram
//  Purpose  : Pattern history table of 2-bit counters. Asynchronous lookup
//             read, asynchronous read of the training entry, and a single
//             synchronous write port whose source is the init sweep or the
//             saturated training value.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pht_ram #(
    parameter int unsigned IDX_W = 8
) (
    input  logic             clk,
    // lookup read
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    // training entry: read current value, write back the stepped value
    input  logic [IDX_W-1:0] upd_idx,
    output logic [1:0]       upd_cur,
    input  logic [1:0]       upd_cnt,
    // write control
    input  logic             wr_en,
    input  logic             init_mode,
    input  logic [IDX_W-1:0] sweep_idx,
    input  logic [1:0]       sweep_cnt
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    // Contents are defined by the sweep, so the array carries no reset.
    logic [1:0] mem [DEPTH];

    logic [IDX_W-1:0] wr_idx;
    logic [1:0]       wr_data;

    assign rd_cnt  = mem[rd_idx];
    assign upd_cur = mem[upd_idx];

    // Write source: sweep data while initialising, trained data otherwise.
    always_comb begin
        wr_idx  = upd_idx;
        wr_data = upd_cnt;
        if (init_mode) begin
            wr_idx  = sweep_idx;
            wr_data = sweep_cnt;
        end
    end

    // Single synchronous write port; reads see the old value this cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/gshare_predictor.sv
// ============================================================================
//  Module   : gshare_predictor
//  Purpose  : Global-history (gshare) branch predictor. PHT indexed by
//             PC ^ GHR, speculative GHR update at lookup, repair on
//             mispredict, post-reset sweep of the table.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gshare_predictor
    import bp_pkg::*;
#(
    parameter int unsigned GHR_WIDTH = 8,
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned PC_LSB    = 2,
    parameter logic [1:0]  CNT_INIT  = CNT_INIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pred_valid,
    input  logic [PC_WIDTH-1:0]  pred_pc,
    output logic                 pred_taken,
    output logic [GHR_WIDTH-1:0] pred_ghr,
    output logic                 ready,
    input  logic                 upd_valid,
    input  logic [PC_WIDTH-1:0]  upd_pc,
    input  logic [GHR_WIDTH-1:0] upd_ghr,
    input  logic                 upd_taken,
    input  logic                 upd_mispredict
);

    localparam int unsigned PHT_DEPTH = 1 << GHR_WIDTH;
    localparam int unsigned IDX_W     = idx_width(PHT_DEPTH);

    bp_state_t            state, state_nxt;
    logic [IDX_W-1:0]     sweep;
    logic [GHR_WIDTH-1:0] ghr;

    logic [IDX_W-1:0]     idx_p, idx_u;
    logic [1:0]           rd_cnt, upd_cur, upd_cnt;
    logic                 in_run, train, repair, wr_en;
    logic                 unused_pc_bits;

    // Only a GHR_WIDTH slice of each PC takes part in indexing.
    assign unused_pc_bits = ^{pred_pc, upd_pc};

    assign idx_p = pred_pc[PC_LSB +: GHR_WIDTH] ^ ghr;
    assign idx_u = upd_pc[PC_LSB +: GHR_WIDTH] ^ upd_ghr;

    assign in_run = (state == RUN);
    assign train  = in_run && upd_valid;
    assign repair = train && upd_mispredict;
    assign wr_en  = !rst && ((state == INIT) || train);

    assign upd_cnt    = cnt_step(upd_cur, upd_taken);
    assign ready      = in_run;
    assign pred_taken = in_run && rd_cnt[1];
    assign pred_ghr   = ghr;

    pht_ram #(
        .IDX_W (IDX_W)
    ) u_pht (
        .clk       (clk),
        .rd_idx    (idx_p),
        .rd_cnt    (rd_cnt),
        .upd_idx   (idx_u),
        .upd_cur   (upd_cur),
        .upd_cnt   (upd_cnt),
        .wr_en     (wr_en),
        .init_mode (state == INIT),
        .sweep_idx (sweep),
        .sweep_cnt (CNT_INIT)
    );

    // State register: reset always restarts the sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave INIT once the last entry has been written.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (sweep == '1) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    // Sweep pointer advances one entry per INIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sweep <= '0;
        end else if (state == INIT) begin
            sweep <= sweep + 1'b1;
        end
    end

    // GHR: repair from the resolved branch wins over the speculative shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (repair) begin
            ghr <= {upd_taken, upd_ghr[GHR_WIDTH-1:1]};
        end else if (in_run && pred_valid) begin
            ghr <= {pred_taken, ghr[GHR_WIDTH-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gshare_predictor.sv
// ============================================================================
//  Module   : tb_gshare_predictor
//  Purpose  : Directed self-checking bench for gshare_predictor.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [7:0]  pred_ghr;
    logic        ready;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [7:0]  upd_ghr;
    logic        upd_taken;
    logic        upd_mispredict;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gshare_predictor dut (
        .clk            (clk),
        .rst            (rst),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .pred_ghr       (pred_ghr),
        .ready          (ready),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_ghr        (upd_ghr),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // advance one edge; inputs change and outputs are sampled 1ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pred_valid = 0; upd_valid = 0; upd_mispredict = 0; upd_taken = 0;
    endtask

    // one training update on the given pc/ghr, no lookup shift
    task automatic train(input logic [31:0] pc, input logic [7:0] g, input logic t);
        upd_valid = 1; upd_pc = pc; upd_ghr = g; upd_taken = t; upd_mispredict = 0;
        pred_valid = 0;
        step();
        upd_valid = 0;
    endtask

    task automatic count_non_init(output int n);
        n = 0;
        for (int i = 0; i < 256; i++) begin
            if (dut.u_pht.mem[i] !== 2'b01) n++;
        end
    endtask

    int n;
    logic [7:0] expg;

    initial begin
        idle();
        pred_pc = 32'h100; upd_pc = 0; upd_ghr = 0;

        // ---- 1. reset + init sweep with pred_valid held high
        rst = 1;
        step();
        rst = 0;
        pred_valid = 1;
        check("reset_ready", {31'd0, ready}, 0);
        for (int i = 0; i < 256; i++) begin
            #1;
            check("init_outputs", {22'd0, ready, pred_taken, pred_ghr}, 0);
            step();
        end
        pred_valid = 0;
        check("ready_at_256", {31'd0, ready}, 1);
        check("ghr_after_init", {24'd0, pred_ghr}, 0);
        count_non_init(n);
        check("pht_all_01", n, 0);

        // ---- 2. training idx 0x40
        pred_pc = 32'h100; #1;
        check("lookup_0x40_init", {31'd0, pred_taken}, 0);
        train(32'h100, 8'h00, 1'b1); #1;
        check("after_1_taken", {31'd0, pred_taken}, 1);
        train(32'h100, 8'h00, 1'b1); #1;
        check("cnt_strong", {30'd0, dut.u_pht.mem[8'h40]}, 3);
        check("pred_strong", {31'd0, pred_taken}, 1);

        // ---- 3. saturation
        for (int i = 0; i < 4; i++) train(32'h100, 8'h00, 1'b1);
        #1;
        check("sat_high", {30'd0, dut.u_pht.mem[8'h40]}, 3);
        train(32'h100, 8'h00, 1'b0); #1;
        check("dec_to_wt", {30'd0, dut.u_pht.mem[8'h40]}, 2);
        check("pred_wt", {31'd0, pred_taken}, 1);
        train(32'h100, 8'h00, 1'b0); #1;
        check("pred_wnt", {31'd0, pred_taken}, 0);
        train(32'h100, 8'h00, 1'b0); #1;
        check("dec_to_snt", {30'd0, dut.u_pht.mem[8'h40]}, 0);
        train(32'h100, 8'h00, 1'b0); #1;
        check("sat_low", {30'd0, dut.u_pht.mem[8'h40]}, 0);
        check("ghr_untouched", {24'd0, pred_ghr}, 0);

        // ---- 4. speculative GHR and repair
        train(32'h40, 8'h00, 1'b1);               // idx 0x10 -> 10
        pred_valid = 1;
        pred_pc = 32'h40; #1;                     // idx 0x10
        check("spec1_pred", {31'd0, pred_taken}, 1);
        step();
        check("spec1_ghr", {24'd0, pred_ghr}, 32'h80);
        pred_pc = 32'h40; #1;                     // idx 0x90 -> 01
        check("spec2_pred", {31'd0, pred_taken}, 0);
        step();
        check("spec2_ghr", {24'd0, pred_ghr}, 32'h40);
        pred_pc = 32'h140; #1;                    // idx 0x50^0x40 = 0x10
        check("spec3_pred", {31'd0, pred_taken}, 1);
        step();
        check("spec3_ghr", {24'd0, pred_ghr}, 32'hA0);
        pred_pc = 32'h40;
        upd_valid = 1; upd_mispredict = 1; upd_ghr = 8'h40; upd_taken = 0;
        upd_pc = 32'h200;
        step();
        check("repair_ghr", {24'd0, pred_ghr}, 32'h20);
        idle();
        upd_mispredict = 1;                       // without upd_valid: no effect
        step();
        upd_mispredict = 0;
        check("misp_no_valid", {24'd0, pred_ghr}, 32'h20);

        // ---- 5. same-cycle lookup and update on idx 0x40
        upd_valid = 1; upd_mispredict = 1; upd_ghr = 8'h00; upd_taken = 0;
        upd_pc = 32'h3FC;                         // repair GHR to 0, trains idx 0xFF
        step();
        idle();
        check("ghr_back_to_0", {24'd0, pred_ghr}, 0);
        train(32'h100, 8'h00, 1'b1);              // 0x40: 00 -> 01
        pred_pc = 32'h100;
        upd_valid = 1; upd_pc = 32'h100; upd_ghr = 0; upd_taken = 1; #1;
        check("collide_same", {31'd0, pred_taken}, 0);
        step();
        upd_valid = 0; #1;
        check("collide_next", {31'd0, pred_taken}, 1);

        // ---- 6. reset in RUN
        train(32'h100, 8'h00, 1'b1); #1;          // 10 -> 11
        check("retrain_strong", {30'd0, dut.u_pht.mem[8'h40]}, 3);
        pred_valid = 1; step(); pred_valid = 0;
        check("ghr_nonzero", {24'd0, pred_ghr}, 32'h80);
        rst = 1;
        step();
        rst = 0;
        check("rst_run_ready", {31'd0, ready}, 0);
        check("rst_run_ghr", {24'd0, pred_ghr}, 0);
        pred_valid = 1;
        upd_valid = 1; upd_mispredict = 1; upd_pc = 32'h100; upd_ghr = 0; upd_taken = 1;
        n = 0;
        for (int i = 0; i < 256; i++) begin
            #1;
            if (ready || pred_taken || pred_ghr != 0) n++;
            step();
        end
        idle();
        check("reinit_quiet", n, 0);
        check("reinit_ready", {31'd0, ready}, 1);
        check("reinit_ghr", {24'd0, pred_ghr}, 0);
        check("reinit_cnt40", {30'd0, dut.u_pht.mem[8'h40]}, 1);
        pred_pc = 32'h100; #1;
        check("reinit_pred", {31'd0, pred_taken}, 0);
        count_non_init(n);
        check("reinit_all_01", n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
